// File: rtl/fp_alu_pkg.sv
// Shared definitions for the FP mantissa ALU: operation codes and the FSM state encoding.
// Used by the top and by the bench.
package fp_alu_pkg;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_RSV = 2'b11;  // executes as ADD

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_MUL_RUN = 2'b01,
    ST_DONE    = 2'b10
  } state_t;

endpackage

// File: rtl/shift_add_mul_core.sv
// Iterative radix-2 shift-add multiplier: one partial product per cycle, always WIDTH steps.
// `last` flags the final step; `product_next` is the accumulator value that step produces.
module shift_add_mul_core #(
  parameter int WIDTH = 27
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   multiplicand,
  input  logic [WIDTH-1:0]   multiplier,
  output logic               last,
  output logic [2*WIDTH-1:0] product_next
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  logic [2*WIDTH-1:0] mcand;
  logic [WIDTH-1:0]   mplier;
  logic [2*WIDTH-1:0] acc;
  logic [CNT_W-1:0]   cnt;
  logic               run;

  // Multiplicand shifts left and multiplier shifts right each step, so step i
  // adds (multiplicand << i) when multiplier bit i is set without a barrel shifter.
  assign product_next = acc + (mplier[0] ? mcand : '0);
  assign last         = run && (cnt == CNT_W'(WIDTH - 1));

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      cnt    <= '0;
      run    <= 1'b0;
    end else if (start) begin
      mcand  <= {{WIDTH{1'b0}}, multiplicand};
      mplier <= multiplier;
      acc    <= '0;
      cnt    <= '0;
      run    <= 1'b1;
    end else if (run) begin
      acc    <= product_next;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt + CNT_W'(1);
      if (last) run <= 1'b0;
    end
  end

endmodule

// File: rtl/mantissa_alu_seq.sv
// Handshaked sign-magnitude mantissa ALU: single-cycle ADD/SUB, iterative MUL,
// result registered and held in DONE until the downstream stage takes it.
module mantissa_alu_seq
  import fp_alu_pkg::*;
#(
  parameter int WIDTH = 27
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   input_a,
  input  logic               sign_a,
  input  logic [WIDTH-1:0]   input_b,
  input  logic               sign_b,
  input  logic [1:0]         operation,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] result,
  output logic               sign_result,
  output logic               carry,
  output logic               busy
);

  state_t             state;
  logic               accept;
  logic               is_mul;
  logic               mul_sign;
  logic               mul_last;
  logic [2*WIDTH-1:0] mul_product;

  logic               eff_sign_b;
  logic [WIDTH:0]     as_mag;
  logic               as_sign;

  assign in_ready  = (state == ST_IDLE);
  assign out_valid = (state == ST_DONE);
  assign busy      = (state == ST_MUL_RUN);
  assign accept    = in_valid && in_ready;
  assign is_mul    = (operation == OP_MUL);

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    as_mag     = '0;
    as_sign    = 1'b0;
    eff_sign_b = sign_b ^ (operation == OP_SUB);
    if (sign_a == eff_sign_b) begin
      as_mag  = {1'b0, input_a} + {1'b0, input_b};
      as_sign = sign_a;
    end else if (input_a > input_b) begin
      as_mag  = {1'b0, input_a - input_b};
      as_sign = sign_a;
    end else if (input_a < input_b) begin
      as_mag  = {1'b0, input_b - input_a};
      as_sign = eff_sign_b;
    end
    // equal magnitudes with opposite signs fall through to +0
  end

  shift_add_mul_core #(.WIDTH(WIDTH)) u_mul (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (accept && is_mul),
    .multiplicand (input_a),
    .multiplier   (input_b),
    .last         (mul_last),
    .product_next (mul_product)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      result      <= '0;
      sign_result <= 1'b0;
      carry       <= 1'b0;
      mul_sign    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            if (is_mul) begin
              mul_sign <= sign_a ^ sign_b;
              state    <= ST_MUL_RUN;
            end else begin
              result      <= {{(WIDTH-1){1'b0}}, as_mag};
              sign_result <= as_sign;
              carry       <= as_mag[WIDTH];
              state       <= ST_DONE;
            end
          end
        end
        ST_MUL_RUN: begin
          if (mul_last) begin
            result      <= mul_product;
            sign_result <= mul_sign;
            carry       <= mul_product[2*WIDTH-1];
            state       <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (out_ready) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mantissa_alu_seq.sv
// Self-checking bench for mantissa_alu_seq: vector table through a scoreboard queue,
// plus backpressure and mid-multiply reset sequences.
module tb_mantissa_alu_seq;
  import fp_alu_pkg::*;

  localparam int W = 27;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           in_valid;
  logic           in_ready;
  logic [W-1:0]   input_a;
  logic           sign_a;
  logic [W-1:0]   input_b;
  logic           sign_b;
  logic [1:0]     operation;
  logic           out_valid;
  logic           out_ready;
  logic [2*W-1:0] result;
  logic           sign_result;
  logic           carry;
  logic           busy;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [1:0]     op;
    logic [W-1:0]   a;
    logic           sa;
    logic [W-1:0]   b;
    logic           sb;
    logic [2*W-1:0] res;
    logic           sr;
    logic           cy;
  } vec_t;

  typedef struct {
    logic [2*W-1:0] res;
    logic           sr;
    logic           cy;
  } exp_t;

  exp_t sb_q[$];
  vec_t vecs[12];

  mantissa_alu_seq #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .input_a     (input_a),
    .sign_a      (sign_a),
    .input_b     (input_b),
    .sign_b      (sign_b),
    .operation   (operation),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .result      (result),
    .sign_result (sign_result),
    .carry       (carry),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Issue one operation, measure latency/busy, compare against the scoreboard,
  // then hold out_ready low for `hold` cycles while poking in_valid.
  task automatic run_op(input vec_t v, input int hold);
    int   n;
    int   busy_n;
    exp_t e;
    @(negedge clk);
    check("in_ready_idle", 64'(in_ready), 64'd1);
    operation = v.op;
    input_a   = v.a;
    sign_a    = v.sa;
    input_b   = v.b;
    sign_b    = v.sb;
    in_valid  = 1'b1;
    sb_q.push_back('{res: v.res, sr: v.sr, cy: v.cy});
    n      = 0;
    busy_n = 0;
    do begin
      @(negedge clk);
      in_valid = 1'b0;
      n++;
      if (busy) busy_n++;
    end while (!out_valid && n < 200);
    check("latency", 64'(n), (v.op == OP_MUL) ? 64'd28 : 64'd1);
    check("busy_cycles", 64'(busy_n), (v.op == OP_MUL) ? 64'd27 : 64'd0);
    if (sb_q.size() == 0) begin
      check("scoreboard_nonempty", 64'd0, 64'd1);
      e = '{res: '0, sr: 1'b0, cy: 1'b0};
    end else begin
      e = sb_q.pop_front();
    end
    check("result", 64'(result), 64'(e.res));
    check("sign_result", 64'(sign_result), 64'(e.sr));
    check("carry", 64'(carry), 64'(e.cy));
    for (int i = 0; i < hold; i++) begin
      operation = OP_ADD;
      input_a   = ~v.a;
      input_b   = v.b ^ 27'h1;
      in_valid  = (i % 2 == 0);
      @(negedge clk);
      check("hold_valid", 64'(out_valid), 64'd1);
      check("hold_in_ready", 64'(in_ready), 64'd0);
      check("hold_result", 64'(result), 64'(e.res));
      check("hold_sign", 64'(sign_result), 64'(e.sr));
      check("hold_carry", 64'(carry), 64'(e.cy));
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("valid_drop", 64'(out_valid), 64'd0);
    check("in_ready_after", 64'(in_ready), 64'd1);
  endtask

  initial begin
    vecs[0]  = '{OP_ADD, 27'd5,         1'b0, 27'd3,         1'b0, 54'd8,                 1'b0, 1'b0};
    vecs[1]  = '{OP_ADD, 27'h7FFFFFF,   1'b0, 27'd1,         1'b0, 54'h8000000,           1'b0, 1'b1};
    vecs[2]  = '{OP_SUB, 27'd3,         1'b0, 27'd5,         1'b0, 54'd2,                 1'b1, 1'b0};
    vecs[3]  = '{OP_ADD, 27'd5,         1'b0, 27'd5,         1'b1, 54'd0,                 1'b0, 1'b0};
    vecs[4]  = '{OP_MUL, 27'd3,         1'b1, 27'd7,         1'b0, 54'd21,                1'b1, 1'b0};
    vecs[5]  = '{OP_SUB, 27'd5,         1'b1, 27'd5,         1'b1, 54'd0,                 1'b0, 1'b0};
    vecs[6]  = '{OP_RSV, 27'd10,        1'b0, 27'd4,         1'b1, 54'd6,                 1'b0, 1'b0};
    vecs[7]  = '{OP_SUB, 27'd2,         1'b1, 27'd9,         1'b0, 54'd11,                1'b1, 1'b0};
    vecs[8]  = '{OP_MUL, 27'h7FFFFFF,   1'b0, 27'h7FFFFFF,   1'b0, 54'h3FFFFFF0000001,    1'b0, 1'b1};
    vecs[9]  = '{OP_MUL, 27'd0,         1'b0, 27'd12345,     1'b1, 54'd0,                 1'b1, 1'b0};
    vecs[10] = '{OP_ADD, 27'h7FFFFFF,   1'b1, 27'h7FFFFFF,   1'b1, 54'hFFFFFFE,           1'b1, 1'b1};
    vecs[11] = '{OP_MUL, 27'd1000,      1'b0, 27'd1000,      1'b1, 54'd1000000,           1'b1, 1'b0};

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    input_a   = '0;
    input_b   = '0;
    sign_a    = 1'b0;
    sign_b    = 1'b0;
    operation = OP_ADD;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_result", 64'(result), 64'd0);
    check("rst_sign", 64'(sign_result), 64'd0);
    check("rst_carry", 64'(carry), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);

    foreach (vecs[i]) run_op(vecs[i], 0);

    // Backpressure on both an ADD and a MUL result
    run_op(vecs[0], 5);
    run_op(vecs[4], 5);

    // Reset pulse at multiply step 10 discards the operation
    begin
      int spurious;
      @(negedge clk);
      operation = OP_MUL;
      input_a   = 27'd77;
      sign_a    = 1'b0;
      input_b   = 27'd99;
      sign_b    = 1'b0;
      in_valid  = 1'b1;
      for (int n = 1; n <= 10; n++) begin
        @(negedge clk);
        in_valid = 1'b0;
      end
      check("mid_mul_busy", 64'(busy), 64'd1);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      check("abort_out_valid", 64'(out_valid), 64'd0);
      check("abort_in_ready", 64'(in_ready), 64'd1);
      check("abort_busy", 64'(busy), 64'd0);
      check("abort_result", 64'(result), 64'd0);
      spurious = 0;
      for (int n = 0; n < 40; n++) begin
        @(negedge clk);
        if (out_valid || busy) spurious++;
      end
      check("abort_no_output", 64'(spurious), 64'd0);
    end
    run_op('{OP_ADD, 27'd1, 1'b0, 27'd1, 1'b0, 54'd2, 1'b0, 1'b0}, 0);

    check("scoreboard_drained", 64'(sb_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
